// File: rtl/regb_fifo_if.sv
// Producer/consumer bundle for regb_fifo. The level signal only exists when
// REGB_FIFO_LEVEL_EN is defined.
interface regb_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             clr;
    logic             shift_in;
    logic [WIDTH-1:0] si;
    logic             shift_out;
    logic [WIDTH-1:0] so;
    logic             empty_n;
    logic             full_n;
    logic             almost_full;
    logic             almost_empty;
    logic             ovf;
    logic             unf;
`ifdef REGB_FIFO_LEVEL_EN
    logic [LW-1:0]    level;
`endif

    modport master (
        output clr, shift_in, si, shift_out,
        input  so, empty_n, full_n, almost_full, almost_empty, ovf, unf
`ifdef REGB_FIFO_LEVEL_EN
        , input level
`endif
    );

    modport slave (
        input  clr, shift_in, si, shift_out,
        output so, empty_n, full_n, almost_full, almost_empty, ovf, unf
`ifdef REGB_FIFO_LEVEL_EN
        , output level
`endif
    );
endinterface

// File: rtl/regb_fifo.sv
// Register-based FIFO built as a thermometer-coded chain of shift cells; head is cell 0.
// Define REGB_FIFO_LEVEL_EN to expose the occupancy count on the level port.
module regb_fifo #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic        clk,
    input  logic        res_n,
    regb_fifo_if.slave  bus
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] d_reg;
    logic [DEPTH-1:0][WIDTH-1:0] d_next;
    logic [DEPTH-1:0]            v_reg;
    logic [DEPTH-1:0]            v_next;
    logic [DEPTH-1:0]            wr_sel;
    logic [LW-1:0]               level_reg;
    logic [LW-1:0]               level_next;
    logic                        ovf_reg;
    logic                        ovf_next;
    logic                        unf_reg;
    logic                        unf_next;
    logic                        pop_eff;
    logic                        push_eff;

    // A flush wins over both requests, so it masks the effective push/pop.
    assign pop_eff  = bus.shift_out & v_reg[0] & ~bus.clr;
    assign push_eff = bus.shift_in & (~v_reg[DEPTH-1] | pop_eff) & ~bus.clr;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_cell
            logic [WIDTH-1:0] up_d;
            logic             up_v;
            logic             down_v;

            if (gi == DEPTH - 1) begin : g_top
                assign up_d = '0;
                assign up_v = 1'b0;
            end else begin : g_mid
                assign up_d = d_reg[gi+1];
                assign up_v = v_reg[gi+1];
            end

            if (gi == 0) begin : g_head
                assign down_v = 1'b1;
            end else begin : g_body
                assign down_v = v_reg[gi-1];
            end

            // Write target from the thermometer edge: first free cell, or the
            // last occupied cell when the chain shifts down in the same cycle.
            assign wr_sel[gi] = push_eff & (pop_eff ? (v_reg[gi] & ~up_v)
                                                    : (~v_reg[gi] & down_v));

            assign d_next[gi] = wr_sel[gi] ? bus.si
                              : (pop_eff ? up_d : d_reg[gi]);
            assign v_next[gi] = bus.clr ? 1'b0
                              : (wr_sel[gi] | (pop_eff ? up_v : v_reg[gi]));
        end
    endgenerate

    always_comb begin
        level_next = level_reg;
        if (bus.clr) begin
            level_next = '0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10:   level_next = level_reg + LW'(1);
                2'b01:   level_next = level_reg - LW'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    always_comb begin
        ovf_next = ovf_reg;
        unf_next = unf_reg;
        if (bus.clr) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
        end else begin
            if (bus.shift_in & v_reg[DEPTH-1] & ~pop_eff)
                ovf_next = 1'b1;
            if (bus.shift_out & ~v_reg[0])
                unf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            d_reg     <= '0;
            v_reg     <= '0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            d_reg     <= d_next;
            v_reg     <= v_next;
            level_reg <= level_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign bus.so           = d_reg[0];
    assign bus.empty_n      = v_reg[0];
    assign bus.full_n       = ~v_reg[DEPTH-1];
    assign bus.almost_full  = (level_reg >= LW'(AF_LEVEL));
    assign bus.almost_empty = (level_reg <= LW'(AE_LEVEL));
    assign bus.ovf          = ovf_reg;
    assign bus.unf          = unf_reg;

`ifdef REGB_FIFO_LEVEL_EN
    assign bus.level = level_reg;
`else
    // Occupancy stays internal and only feeds the almost flags.
`endif
endmodule

// File: tb/tb_regb_fifo.sv
// Directed bench for regb_fifo (WIDTH=4, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_regb_fifo;
    logic clk;
    logic res_n;
    int   total;
    int   bad;

    regb_fifo_if #(.WIDTH(4), .DEPTH(8)) bus ();

    regb_fifo #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h @%0t", tag, got, $time);
        end
    endtask

    task automatic chk_level(input string tag, input int exp);
`ifdef REGB_FIFO_LEVEL_EN
        chk(tag, 32'(bus.level), 32'(exp));
`else
        chk({tag, "_af"}, 32'(bus.almost_full), 32'(exp >= 6));
`endif
    endtask

    // Drive one cycle of requests, sample 1 time unit after the edge, then idle.
    task automatic cyc(input logic in, input logic [3:0] d, input logic out, input logic c);
        bus.shift_in  = in;
        bus.si        = d;
        bus.shift_out = out;
        bus.clr       = c;
        @(posedge clk);
        #1;
        bus.shift_in  = 1'b0;
        bus.shift_out = 1'b0;
        bus.clr       = 1'b0;
    endtask

    task automatic fill_1_to_8();
        for (int k = 1; k <= 8; k++) cyc(1'b1, 4'(k), 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        res_n = 1'b0;
        bus.shift_in  = 1'b0;
        bus.shift_out = 1'b0;
        bus.clr       = 1'b0;
        bus.si        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_so", 32'(bus.so), 0);
        chk("rst_empty_n", 32'(bus.empty_n), 0);
        chk("rst_full_n", 32'(bus.full_n), 1);
        chk("rst_af", 32'(bus.almost_full), 0);
        chk("rst_ae", 32'(bus.almost_empty), 1);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_unf", 32'(bus.unf), 0);
        chk_level("rst_level", 0);
        @(negedge clk);
        res_n = 1'b1;
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        chk("idle_empty_n", 32'(bus.empty_n), 0);

        // Fill, watching flags at each level, then drain in order.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 4'(k), 1'b0, 1'b0);
            chk($sformatf("fill%0d_full_n", k), 32'(bus.full_n), 32'(k < 8));
            chk($sformatf("fill%0d_af", k), 32'(bus.almost_full), 32'(k >= 6));
            chk($sformatf("fill%0d_ae", k), 32'(bus.almost_empty), 32'(k <= 2));
            chk($sformatf("fill%0d_so", k), 32'(bus.so), 1);
        end
        chk_level("full_level", 8);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain%0d_so", k), 32'(bus.so), 32'(k));
            cyc(1'b0, 4'd0, 1'b1, 1'b0);
        end
        chk("drained_empty_n", 32'(bus.empty_n), 0);
        chk("drained_full_n", 32'(bus.full_n), 1);

        // Write while full is dropped and flagged.
        fill_1_to_8();
        cyc(1'b1, 4'd9, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.ovf), 1);
        chk("ovf_full_n", 32'(bus.full_n), 0);
        chk_level("ovf_level", 8);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("ovf_pop%0d_so", k), 32'(bus.so), 32'(k));
            cyc(1'b0, 4'd0, 1'b1, 1'b0);
        end
        chk("ovf_sticky", 32'(bus.ovf), 1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.ovf), 0);

        // Push+pop on full keeps level at DEPTH with one word per cycle.
        fill_1_to_8();
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("pp%0d_so", k), 32'(bus.so), 32'(k));
            cyc(1'b1, 4'd9, 1'b1, 1'b0);
            chk($sformatf("pp%0d_full_n", k), 32'(bus.full_n), 0);
            chk($sformatf("pp%0d_ovf", k), 32'(bus.ovf), 0);
        end
        chk_level("pp_level", 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pp_drain%0d_so", k), 32'(bus.so), 32'((k < 5) ? k + 4 : 9));
            cyc(1'b0, 4'd0, 1'b1, 1'b0);
        end
        chk("pp_empty_n", 32'(bus.empty_n), 0);
        chk("pp_unf", 32'(bus.unf), 0);

        // Underflow, push+pop on empty, then flush over a write.
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk("unf_set", 32'(bus.unf), 1);
        chk("unf_empty_n", 32'(bus.empty_n), 0);
        cyc(1'b1, 4'd7, 1'b1, 1'b0);
        chk("epp_empty_n", 32'(bus.empty_n), 1);
        chk("epp_so", 32'(bus.so), 7);
        chk("epp_unf", 32'(bus.unf), 1);
        chk_level("epp_level", 1);
        cyc(1'b1, 4'd3, 1'b0, 1'b1);
        chk("clr_unf", 32'(bus.unf), 0);
        chk("clr_ovf", 32'(bus.ovf), 0);
        chk("clr_empty_n", 32'(bus.empty_n), 0);
        chk_level("clr_level", 0);

        // Asynchronous reset between edges.
        for (int k = 1; k <= 3; k++) cyc(1'b1, 4'(k + 10), 1'b0, 1'b0);
        chk("pre_arst_so", 32'(bus.so), 11);
        #3;
        res_n = 1'b0;
        #1;
        chk("arst_so", 32'(bus.so), 0);
        chk("arst_empty_n", 32'(bus.empty_n), 0);
        chk("arst_full_n", 32'(bus.full_n), 1);
        chk("arst_ae", 32'(bus.almost_empty), 1);
        chk_level("arst_level", 0);
        @(negedge clk);
        res_n = 1'b1;
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        chk("post_arst_so", 32'(bus.so), 5);
        chk("post_arst_empty_n", 32'(bus.empty_n), 1);
        chk_level("post_arst_level", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
